// File: rtl/pwm_meter_pkg.sv
// Shared types for the pulse width meter: FSM state encoding and the
// default-width result record.
package pwm_meter_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   // Result record at the default counter width; the top builds the same
   // layout at its own CNT_W.
   typedef struct packed {
      logic                 sat;
      logic [CNT_W_DEF:0]   period;
      logic [CNT_W_DEF-1:0] high_time;
   } result_t;

endpackage

// File: rtl/sat_counter.sv
// Cycle counter with clear / load-1 / increment and a saturation flag that
// persists until explicitly cleared, so it can span both phases of a period.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load1,
   input  logic         inc,
   input  logic         sat_clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] MAX = '1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sat <= 1'b0;
      end else begin
         if (clear) begin
            cnt <= '0;
         end else if (load1) begin
            cnt <= W'(1);
         end else if (inc && cnt != MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (clear || sat_clr) begin
            sat <= 1'b0;
         end else if (inc && !load1 && cnt == MAX) begin
            sat <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high time and period of a signal from its rise/fall event pulses
// and offers one registered result per completed rise->fall->rise cycle.
module pulse_width_meter
   import pwm_meter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             rise_pulse,
   input  logic             fall_pulse,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W:0]   period,
   output logic             sat,
   output logic             overrun,
   output logic             proto_err,
   input  logic             clear_err
);

   typedef struct packed {
      logic             sat;
      logic [CNT_W:0]   period;
      logic [CNT_W-1:0] high_time;
   } meas_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_sat;
   logic [CNT_W-1:0] high_q;
   meas_t            res_q;
   meas_t            res_new;

   logic cnt_clear, cnt_load, cnt_inc, sat_clr;
   logic high_load, emit, proto_set;

   // Simultaneous rise and fall is treated as no event (plus an error).
   logic rise_ev, fall_ev, both_ev;
   assign rise_ev = rise_pulse & ~fall_pulse;
   assign fall_ev = fall_pulse & ~rise_pulse;
   assign both_ev = rise_pulse & fall_pulse;

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (cnt_clear),
      .load1   (cnt_load),
      .inc     (cnt_inc),
      .sat_clr (sat_clr),
      .cnt     (cnt),
      .sat     (cnt_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned
      // and no latch is inferred.
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (rise_ev) state_nxt = HIGH;
            HIGH:    if (fall_ev) state_nxt = LOW;
            LOW: begin
               if (rise_ev)      state_nxt = HIGH;
               else if (fall_ev) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_clear = 1'b0;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      sat_clr   = 1'b0;
      high_load = 1'b0;
      emit      = 1'b0;
      proto_set = 1'b0;
      if (!enable) begin
         cnt_clear = 1'b1;
      end else begin
         proto_set = both_ev;
         case (state)
            IDLE: begin
               if (rise_ev) begin
                  cnt_load = 1'b1;
                  sat_clr  = 1'b1;
               end
            end
            HIGH: begin
               if (fall_ev) begin
                  high_load = 1'b1;
                  cnt_load  = 1'b1;
               end else if (rise_ev) begin
                  proto_set = 1'b1;
                  cnt_load  = 1'b1;
                  sat_clr   = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            LOW: begin
               if (rise_ev) begin
                  emit     = 1'b1;
                  cnt_load = 1'b1;
                  sat_clr  = 1'b1;
               end else if (fall_ev) begin
                  proto_set = 1'b1;
                  cnt_clear = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: cnt_clear = 1'b1;
         endcase
      end
   end

   // The counter's sat bit survives the fall, so a saturated high phase is
   // still reported at the end of the period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_q <= '0;
      end else if (high_load) begin
         high_q <= cnt;
      end
   end

   always_comb begin
      res_new.high_time = high_q;
      res_new.period    = {1'b0, high_q} + {1'b0, cnt};
      res_new.sat       = cnt_sat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q     <= '0;
         out_valid <= 1'b0;
      end else if (emit && (!out_valid || out_ready)) begin
         res_q     <= res_new;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         proto_err <= 1'b0;
      end else if (clear_err) begin
         overrun   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (emit && out_valid && !out_ready) overrun <= 1'b1;
         if (proto_set) proto_err <= 1'b1;
      end
   end

   assign high_time = res_q.high_time;
   assign period    = res_q.period;
   assign sat       = res_q.sat;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter at CNT_W=16, with a CNT_W=4 copy
// sharing the stimulus for the saturation case.
module tb_pulse_width_meter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        rise_pulse;
   logic        fall_pulse;
   logic        out_ready;
   logic        clear_err;

   logic        out_valid;
   logic [15:0] high_time;
   logic [16:0] period;
   logic        sat;
   logic        overrun;
   logic        proto_err;

   logic        v4;
   logic [3:0]  ht4;
   logic [4:0]  per4;
   logic        sat4;
   logic        ovr4;
   logic        perr4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pulse_width_meter #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .high_time  (high_time),
      .period     (period),
      .sat        (sat),
      .overrun    (overrun),
      .proto_err  (proto_err),
      .clear_err  (clear_err)
   );

   pulse_width_meter #(.CNT_W(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .out_ready  (out_ready),
      .out_valid  (v4),
      .high_time  (ht4),
      .period     (per4),
      .sat        (sat4),
      .overrun    (ovr4),
      .proto_err  (perr4),
      .clear_err  (clear_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // One clock with the given event pulses; returns #1 after the edge.
   task automatic step(input logic r, input logic f);
      rise_pulse = r;
      fall_pulse = f;
      @(posedge clk);
      #1;
      rise_pulse = 1'b0;
      fall_pulse = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      enable     = 1'b1;
      rise_pulse = 1'b0;
      fall_pulse = 1'b0;
      out_ready  = 1'b1;
      clear_err  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_result(input string tag, input int h, input int p, input logic s);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".high"},  32'(high_time), 32'(h));
      check({tag, ".period"}, 32'(period),   32'(p));
      check({tag, ".sat"},   32'(sat),       32'(s));
   endtask

   initial begin
      do_reset();

      // Reset state
      check("rst.valid",  32'(out_valid), 32'd0);
      check("rst.high",   32'(high_time), 32'd0);
      check("rst.period", 32'(period),    32'd0);
      check("rst.sat",    32'(sat),       32'd0);
      check("rst.ovr",    32'(overrun),   32'd0);
      check("rst.perr",   32'(proto_err), 32'd0);
      check("rst.v4",     32'(v4),        32'd0);
      check("rst.ovr4",   32'(ovr4),      32'd0);
      check("rst.perr4",  32'(perr4),     32'd0);

      // 1: rise@0, fall@5, rise@12
      step(1'b1, 1'b0);
      idle(4);
      step(1'b0, 1'b1);
      idle(6);
      check("t1.early", 32'(out_valid), 32'd0);
      step(1'b1, 1'b0);
      check_result("t1", 5, 12, 1'b0);
      idle(1);
      check("t1.drop", 32'(out_valid), 32'd0);

      // 2: 3-high / 4-low wave, four rises -> three results
      do_reset();
      for (int p = 0; p < 4; p++) begin
         step(1'b1, 1'b0);
         if (p == 0) check("t2.arm", 32'(out_valid), 32'd0);
         else        check_result($sformatf("t2.r%0d", p), 3, 7, 1'b0);
         idle(2);
         step(1'b0, 1'b1);
         idle(3);
      end
      check("t2.perr", 32'(proto_err), 32'd0);

      // 3: consumer stalled across two results
      do_reset();
      out_ready = 1'b0;
      step(1'b1, 1'b0);
      idle(1);
      step(1'b0, 1'b1);
      idle(2);
      step(1'b1, 1'b0);
      check_result("t3.first", 2, 5, 1'b0);
      check("t3.ovr0", 32'(overrun), 32'd0);
      idle(3);
      step(1'b0, 1'b1);
      idle(2);
      step(1'b1, 1'b0);
      check_result("t3.held", 2, 5, 1'b0);
      check("t3.ovr1", 32'(overrun), 32'd1);
      out_ready = 1'b1;
      idle(1);
      check("t3.accept", 32'(out_valid), 32'd0);
      check("t3.ovr_sticky", 32'(overrun), 32'd1);
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      check("t3.clr", 32'(overrun), 32'd0);

      // 4: 20 high, 2 low; 4-bit copy saturates
      do_reset();
      step(1'b1, 1'b0);
      idle(19);
      step(1'b0, 1'b1);
      idle(1);
      step(1'b1, 1'b0);
      check("t4.v4",   32'(v4),   32'd1);
      check("t4.ht4",  32'(ht4),  32'd15);
      check("t4.per4", 32'(per4), 32'd17);
      check("t4.sat4", 32'(sat4), 32'd1);
      check_result("t4.w16", 20, 22, 1'b0);

      // 5: rise,rise without fall; then rise&fall together
      do_reset();
      step(1'b1, 1'b0);
      idle(2);
      step(1'b1, 1'b0);
      check("t5.perr", 32'(proto_err), 32'd1);
      check("t5.nores", 32'(out_valid), 32'd0);
      idle(3);
      step(1'b0, 1'b1);
      idle(1);
      step(1'b1, 1'b0);
      check_result("t5.restart", 4, 6, 1'b0);
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      check("t5.clr", 32'(proto_err), 32'd0);
      step(1'b1, 1'b1);
      check("t5.both", 32'(proto_err), 32'd1);
      idle(1);
      step(1'b0, 1'b1);
      idle(1);
      step(1'b1, 1'b0);
      check_result("t5.after_both", 4, 6, 1'b0);

      // 6: enable drop mid-HIGH, then async reset while a result is held
      do_reset();
      out_ready = 1'b0;
      step(1'b1, 1'b0);
      idle(2);
      enable = 1'b0;
      idle(1);
      enable = 1'b1;
      check("t6.nores", 32'(out_valid), 32'd0);
      step(1'b0, 1'b1);
      check("t6.idle_fall", 32'(proto_err), 32'd0);
      step(1'b1, 1'b0);
      check("t6.arm", 32'(out_valid), 32'd0);
      idle(1);
      step(1'b0, 1'b1);
      idle(2);
      step(1'b1, 1'b0);
      check_result("t6.res", 2, 5, 1'b0);
      step(1'b1, 1'b0);
      check("t6.perr", 32'(proto_err), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6.rst_valid",  32'(out_valid), 32'd0);
      check("t6.rst_high",   32'(high_time), 32'd0);
      check("t6.rst_period", 32'(period),    32'd0);
      check("t6.rst_perr",   32'(proto_err), 32'd0);
      check("t6.rst_ovr",    32'(overrun),   32'd0);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
